runner_game_core: RTL and testbench
===================================

// Module: runner_game_core
// PURPOSE
//  Parametrised side-scroller game engine plus pixel colouring. N_OBS obstacles, signed jump physics,
//  pause mode, saturating score, session high score. Sits between the VGA display controller
//  (hCount/vCount/bright) and the 7-seg score driver. Game state advances only on a per-frame tick.
// PARAMETERS
//  N_OBS      3    obstacles in flight (1..4)
//  BLK        50   sprite edge in pixels (dino and obstacles)
//  DINO_X     200  dino left edge, hCount units
//  GROUND_Y   515  ground line (sprite bottom), vCount units
//  SPAWN_X    800  obstacle centre on respawn
//  DESPAWN_X  150  obstacle respawns when centre <= this
//  SPACING    220  initial centre spacing between obstacles
//  JUMP_V     30   jump launch speed, px/tick upward
//  GRAVITY    2    px/tick^2
//  SPD_MIN    6    initial/reset obstacle speed, px/tick
//  SPD_MAX    15   speed after which speed wraps to SPD_MIN
//  SCORE_W    16   score/hi_score width
//  FLASH      15   message visible while msg_cnt <= FLASH (msg_cnt 6-bit, wraps at 64)
// PORTS
//  clk       in   1        system clock
//  rst       in   1        synchronous, active-high reset
//  tick      in   1        one-cycle frame-step pulse; all game updates gated by it
//  bright    in   1        display-area valid
//  up        in   1        jump/start button (debounced, level)
//  pause     in   1        pause button (debounced, level)
//  hCount    in   10       current pixel column
//  vCount    in   10       current pixel row
//  rgb       out  12       pixel colour, combinational from registers
//  score     out  SCORE_W  current score
//  hi_score  out  SCORE_W  best score since rst
//  state     out  4        one-hot: INI=0001 GAME=0010 PAUSE=0100 DONE=1000
//  collide   out  1        1-tick-wide pulse (registered) on the tick a collision is detected
// BEHAVIOUR
//  Reset: state=INI, score=0, hi_score=0, collide=0, ypos=GROUND_Y, yvel=0, on_ground=1,
//   obstacle i centre=SPAWN_X+i*SPACING, speed=SPD_MIN, msg_cnt=0. No X values anywhere.
//  Edges: rising edges of up/pause detected every clk and held in sticky flags; flags consumed and
//   cleared on the next tick. Edge and tick in the same cycle: edge is consumed that tick.
//  INI: msg_cnt++ per tick; up_rise -> GAME, msg_cnt=0, all game regs reloaded to reset values
//   (hi_score kept).
//  GAME (per tick, all from pre-tick values):
//   obstacles: x -= speed; if x <= DESPAWN_X then x=SPAWN_X, speed = (speed==SPD_MAX)?SPD_MIN:speed+1
//    (speed is per-obstacle).
//   jump: on_ground & up_rise -> yvel=-JUMP_V, on_ground=0. Airborne: ypos+=yvel, yvel+=GRAVITY
//    (yvel signed 10-bit). If airborne and ypos+yvel >= GROUND_Y: ypos=GROUND_Y, yvel=0, on_ground=1.
//   score: +1 per tick, saturates at 2^SCORE_W-1.
//   collision: any obstacle with DINO_X-BLK/2 <= x <= DINO_X+BLK+BLK/2 and ypos > GROUND_Y-BLK ->
//    state DONE, collide=1 for that tick; collision beats pause and jump in the same tick.
//   pause_rise (no collision) -> PAUSE.
//  PAUSE: all game regs frozen; msg_cnt++; pause_rise -> GAME, msg_cnt=0. up ignored.
//  DONE: on entry hi_score = max(hi_score, score); msg_cnt++; up_rise -> INI, msg_cnt=0.
//  Render priority: ~bright -> 0; dino (red F00) box [DINO_X..DINO_X+BLK]x[ypos-BLK..ypos], not in INI;
//   obstacles (white FFF) box [x-BLK/2..x+BLK/2]x[GROUND_Y-BLK..GROUND_Y], not in INI; message red
//   when msg_cnt <= FLASH: INI square at (450,250), PAUSE two bars, DONE letter F; else 0.
//  Comparisons done at 11 bits to avoid wrap when x-BLK/2 or ypos-BLK underflow.
//  rst mid-game: returns to reset values next clk; hi_score cleared.
// STRUCTURE
//  runner_pkg: state encodings, colour constants, SCORE_W default.
//  runner_obstacle sub-module (x, speed, respawn logic, box hit/fill outputs), generated N_OBS times;
//   top ORs fill/hit vectors. Physics, FSM, score, renderer in top.
// TESTING
//  1 rst, then up pulse + tick -> state=0010, score=0, obstacle0 x=800, speeds=6.
//  2 GAME, no input, 10 ticks -> score=10, obstacle0 x=740; tick without up edge changes nothing else.
//  3 up_rise on ground -> ypos 515,485,457,... back to 515, on_ground=1 after 31 ticks; second up
//    while airborne ignored.
//  4 obstacle at x=151, speed 15, tick -> x=800? no: x=136 then respawn next tick: x=800, speed=6.
//  5 force obstacle to x=225 with dino grounded -> collide pulse 1 tick, state=1000, hi_score=score;
//    new game with lower score leaves hi_score unchanged.
//  6 pause_rise in GAME -> 0100, 20 ticks: score/positions frozen; pause_rise -> 0010; score at 2^16-1 holds.

Source files
------------

// File: rtl/runner_pkg.sv
// Shared state encodings, colours and box test helper for the runner game core.
package runner_pkg;

  typedef enum logic [3:0] {
    ST_INI   = 4'b0001,
    ST_GAME  = 4'b0010,
    ST_PAUSE = 4'b0100,
    ST_DONE  = 4'b1000
  } state_t;

  localparam logic [11:0] RGB_OFF   = 12'h000;
  localparam logic [11:0] RGB_RED   = 12'hF00;
  localparam logic [11:0] RGB_WHITE = 12'hFFF;

  localparam int SCORE_W_DEF = 16;

  // anchor of the INI/PAUSE/DONE message glyphs
  localparam int MSG_X = 450;
  localparam int MSG_Y = 250;

  function automatic logic in_box(input logic [10:0] px, input logic [10:0] py,
                                  input logic [10:0] x0, input logic [10:0] x1,
                                  input logic [10:0] y0, input logic [10:0] y1);
    return (px >= x0) && (px <= x1) && (py >= y0) && (py <= y1);
  endfunction

endpackage

// File: rtl/runner_game_core_if.sv
// Display, button and score signals exchanged with the runner game core.
interface runner_game_core_if
  import runner_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF
);
  logic               tick;
  logic               bright;
  logic               up;
  logic               pause;
  logic [9:0]         hCount;
  logic [9:0]         vCount;
  logic [11:0]        rgb;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] hi_score;
  logic [3:0]         state;
  logic               collide;

  modport master (
    output tick, bright, up, pause, hCount, vCount,
    input  rgb, score, hi_score, state, collide
  );

  modport slave (
    input  tick, bright, up, pause, hCount, vCount,
    output rgb, score, hi_score, state, collide
  );
endinterface

// File: rtl/runner_obstacle.sv
// One scrolling obstacle: centre position, its own speed, respawn, and hit/fill box tests.
module runner_obstacle
  import runner_pkg::*;
#(
  parameter int INIT_X    = 800,
  parameter int BLK       = 50,
  parameter int DINO_X    = 200,
  parameter int GROUND_Y  = 515,
  parameter int SPAWN_X   = 800,
  parameter int DESPAWN_X = 150,
  parameter int SPD_MIN   = 6,
  parameter int SPD_MAX   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [10:0] px,
  input  logic [10:0] py,
  output logic        hit,
  output logic        fill
);

  logic [10:0] x;
  logic [4:0]  speed;

  // respawn decision uses the pre-step centre, so an obstacle may sit below DESPAWN_X for one frame
  always_ff @(posedge clk) begin
    if (rst || load) begin
      x     <= 11'(INIT_X);
      speed <= 5'(SPD_MIN);
    end else if (step) begin
      if (x <= 11'(DESPAWN_X)) begin
        x     <= 11'(SPAWN_X);
        speed <= (speed == 5'(SPD_MAX)) ? 5'(SPD_MIN) : speed + 5'd1;
      end else begin
        x <= x - {6'd0, speed};
      end
    end
  end

  assign hit  = (x >= 11'(DINO_X - BLK/2)) && (x <= 11'(DINO_X + BLK + BLK/2));
  assign fill = in_box(px, py, x - 11'(BLK/2), x + 11'(BLK/2),
                       11'(GROUND_Y - BLK), 11'(GROUND_Y));

endmodule

// File: rtl/runner_game_core.sv
// Side-scroller engine: game FSM, jump physics, score, obstacle array and pixel colouring.
//  state    | meaning
//  ST_INI   | title screen, flashing square, waits for up
//  ST_GAME  | obstacles scroll, dino jumps, score counts
//  ST_PAUSE | everything frozen, flashing bars, waits for pause
//  ST_DONE  | crash scene frozen, flashing F, waits for up
module runner_game_core
  import runner_pkg::*;
#(
  parameter int N_OBS     = 3,
  parameter int BLK       = 50,
  parameter int DINO_X    = 200,
  parameter int GROUND_Y  = 515,
  parameter int SPAWN_X   = 800,
  parameter int DESPAWN_X = 150,
  parameter int SPACING   = 220,
  parameter int JUMP_V    = 30,
  parameter int GRAVITY   = 2,
  parameter int SPD_MIN   = 6,
  parameter int SPD_MAX   = 15,
  parameter int SCORE_W   = SCORE_W_DEF,
  parameter int FLASH     = 15
) (
  input logic               clk,
  input logic               rst,
  runner_game_core_if.slave bus
);

  localparam logic signed [10:0] GROUND_S  = 11'(GROUND_Y);
  localparam logic signed [9:0]  JUMP_S    = 10'(-JUMP_V);
  localparam logic signed [9:0]  GRAV_S    = 10'(GRAVITY);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_t st, st_nxt;
  logic   up_q, pause_q, up_flag, pause_flag, up_ev, pause_ev;
  logic   game_load, game_step, msg_clr, hit_now, crash;

  logic [9:0]         ypos;
  logic signed [9:0]  yvel;
  logic               on_ground;
  logic signed [10:0] y_sum;
  logic [SCORE_W-1:0] score_q, hi_q;
  logic               collide_q;
  logic [5:0]         msg_cnt;

  logic [10:0]      px, py;
  logic [N_OBS-1:0] obs_hit, obs_fill;
  logic             dino_fill, msg_fill;
  logic [11:0]      rgb_px;

  // an edge arriving in the tick cycle itself is consumed by that tick
  assign up_ev    = up_flag    | (bus.up    & ~up_q);
  assign pause_ev = pause_flag | (bus.pause & ~pause_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      up_q       <= 1'b0;
      pause_q    <= 1'b0;
      up_flag    <= 1'b0;
      pause_flag <= 1'b0;
    end else begin
      up_q       <= bus.up;
      pause_q    <= bus.pause;
      up_flag    <= up_ev & ~bus.tick;
      pause_flag <= pause_ev & ~bus.tick;
    end
  end

  assign px = {1'b0, bus.hCount};
  assign py = {1'b0, bus.vCount};

  for (genvar i = 0; i < N_OBS; i++) begin : g_obs
    runner_obstacle #(
      .INIT_X   (SPAWN_X + i * SPACING),
      .BLK      (BLK),
      .DINO_X   (DINO_X),
      .GROUND_Y (GROUND_Y),
      .SPAWN_X  (SPAWN_X),
      .DESPAWN_X(DESPAWN_X),
      .SPD_MIN  (SPD_MIN),
      .SPD_MAX  (SPD_MAX)
    ) u_obs (
      .clk (clk),
      .rst (rst),
      .load(game_load),
      .step(game_step),
      .px  (px),
      .py  (py),
      .hit (obs_hit[i]),
      .fill(obs_fill[i])
    );
  end

  assign crash = (|obs_hit) && ({1'b0, ypos} > 11'(GROUND_Y - BLK));

  always_ff @(posedge clk) begin
    if (rst) st <= ST_INI;
    else     st <= st_nxt;
  end

  // a crash freezes the scene as it was, so no step, jump or pause happens on that tick
  always_comb begin
    st_nxt    = st;
    game_load = 1'b0;
    game_step = 1'b0;
    msg_clr   = 1'b0;
    hit_now   = 1'b0;
    if (bus.tick) begin
      case (st)
        ST_INI: if (up_ev) begin
          st_nxt    = ST_GAME;
          game_load = 1'b1;
          msg_clr   = 1'b1;
        end
        ST_GAME: if (crash) begin
          st_nxt  = ST_DONE;
          hit_now = 1'b1;
        end else begin
          game_step = 1'b1;
          if (pause_ev) st_nxt = ST_PAUSE;
        end
        ST_PAUSE: if (pause_ev) begin
          st_nxt  = ST_GAME;
          msg_clr = 1'b1;
        end
        ST_DONE: if (up_ev) begin
          st_nxt  = ST_INI;
          msg_clr = 1'b1;
        end
        default: st_nxt = ST_INI;
      endcase
    end
  end

  assign y_sum = $signed({1'b0, ypos}) + $signed({yvel[9], yvel});

  always_ff @(posedge clk) begin
    if (rst || game_load) begin
      ypos      <= 10'(GROUND_Y);
      yvel      <= '0;
      on_ground <= 1'b1;
    end else if (game_step) begin
      if (on_ground) begin
        if (up_ev) begin
          yvel      <= JUMP_S;
          on_ground <= 1'b0;
        end
      end else if (y_sum >= GROUND_S) begin
        ypos      <= 10'(GROUND_Y);
        yvel      <= '0;
        on_ground <= 1'b1;
      end else begin
        ypos <= y_sum[9:0];
        yvel <= yvel + GRAV_S;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score_q   <= '0;
      hi_q      <= '0;
      collide_q <= 1'b0;
      msg_cnt   <= '0;
    end else begin
      if (game_load)                                score_q <= '0;
      else if (game_step && score_q != SCORE_MAX)   score_q <= score_q + SCORE_W'(1);
      if (hit_now && score_q > hi_q)                hi_q    <= score_q;
      if (bus.tick)                                 collide_q <= hit_now;
      if (msg_clr)                                  msg_cnt <= '0;
      else if (bus.tick && st != ST_GAME)           msg_cnt <= msg_cnt + 6'd1;
    end
  end

  assign dino_fill = in_box(px, py, 11'(DINO_X), 11'(DINO_X + BLK),
                            {1'b0, ypos} - 11'(BLK), {1'b0, ypos});

  always_comb begin
    msg_fill = 1'b0;
    case (st)
      ST_INI:   msg_fill = in_box(px, py, 11'(MSG_X), 11'(MSG_X + 50), 11'(MSG_Y), 11'(MSG_Y + 50));
      ST_PAUSE: msg_fill = in_box(px, py, 11'(MSG_X - 10), 11'(MSG_X + 10), 11'(MSG_Y - 30), 11'(MSG_Y + 50))
                        || in_box(px, py, 11'(MSG_X + 40), 11'(MSG_X + 60), 11'(MSG_Y - 30), 11'(MSG_Y + 50));
      ST_DONE:  msg_fill = in_box(px, py, 11'(MSG_X - 20), 11'(MSG_X), 11'(MSG_Y - 30), 11'(MSG_Y + 70))
                        || in_box(px, py, 11'(MSG_X - 20), 11'(MSG_X + 60), 11'(MSG_Y - 30), 11'(MSG_Y - 10))
                        || in_box(px, py, 11'(MSG_X - 20), 11'(MSG_X + 40), 11'(MSG_Y + 10), 11'(MSG_Y + 30));
      default:  msg_fill = 1'b0;
    endcase
  end

  always_comb begin
    rgb_px = RGB_OFF;
    if (bus.bright) begin
      if (st != ST_INI && dino_fill)             rgb_px = RGB_RED;
      else if (st != ST_INI && (|obs_fill))      rgb_px = RGB_WHITE;
      else if (msg_cnt <= 6'(FLASH) && msg_fill) rgb_px = RGB_RED;
    end
  end

  assign bus.rgb      = rgb_px;
  assign bus.score    = score_q;
  assign bus.hi_score = hi_q;
  assign bus.state    = st;
  assign bus.collide  = collide_q;

endmodule

// File: tb/tb_runner_game_core.sv
// Randomised frame-level bench for runner_game_core with a closed-form game model and scoreboard.
module tb_runner_game_core;

  localparam int NOBS = 3, BLK = 50, DINO_X = 200, GROUND = 515, SPAWN = 800;
  localparam int DESPAWN = 150, SPACING = 220, JV = 30, GR = 2, SPMIN = 6, SPMAX = 15;
  localparam int SW = 7, SMAX = (1 << SW) - 1, FLASH = 15, N_STEPS = 3000;
  localparam int S_INI = 1, S_GAME = 2, S_PAUSE = 4, S_DONE = 8;

  typedef struct { int st; int sc; int hi; int col; int rgb; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  runner_game_core_if #(.SCORE_W(SW)) bus();

  runner_game_core #(.N_OBS(NOBS), .SCORE_W(SW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   n_chk = 0, n_fail = 0;
  exp_t exp_q[$];

  int m_state, m_score, m_hi, m_col, m_msg, m_air;
  int m_x[NOBS], m_spd[NOBS];
  bit pend_up, pend_pause;
  int px_h, px_v;
  bit px_b;

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp_v, exp_v, $time);
    end
  endtask

  // height above ground n frames after launch
  function automatic int height(input int n);
    return n * JV - GR * n * (n - 1) / 2;
  endfunction

  function automatic int m_ypos();
    if (m_air < 0) return GROUND;
    return GROUND - height(m_air);
  endfunction

  function automatic bit m_crash();
    int d;
    for (int i = 0; i < NOBS; i++) begin
      d = m_x[i] - (DINO_X + BLK / 2);
      if (d < 0) d = -d;
      if (d <= BLK && (GROUND - m_ypos()) < BLK) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit inb(input int h, input int v, input int x0, input int x1, input int y0, input int y1);
    return h >= x0 && h <= x1 && v >= y0 && v <= y1;
  endfunction

  function automatic int model_rgb(input int h, input int v, input bit br);
    int y;
    y = m_ypos();
    if (!br) return 0;
    if (m_state != S_INI) begin
      if (inb(h, v, DINO_X, DINO_X + BLK, y - BLK, y)) return 'hF00;
      for (int i = 0; i < NOBS; i++)
        if (inb(h, v, m_x[i] - BLK / 2, m_x[i] + BLK / 2, GROUND - BLK, GROUND)) return 'hFFF;
    end
    if (m_msg <= FLASH) begin
      if (m_state == S_INI && inb(h, v, 450, 500, 250, 300)) return 'hF00;
      if (m_state == S_PAUSE && (inb(h, v, 440, 460, 220, 300) || inb(h, v, 490, 510, 220, 300))) return 'hF00;
      if (m_state == S_DONE && (inb(h, v, 430, 450, 220, 320) || inb(h, v, 430, 510, 220, 240)
                                || inb(h, v, 430, 490, 260, 280))) return 'hF00;
    end
    return 0;
  endfunction

  task automatic model_new_game();
    m_score = 0;
    m_air   = -1;
    for (int i = 0; i < NOBS; i++) begin
      m_x[i]   = SPAWN + i * SPACING;
      m_spd[i] = SPMIN;
    end
  endtask

  task automatic model_reset();
    model_new_game();
    m_state = S_INI; m_hi = 0; m_col = 0; m_msg = 0;
    pend_up = 0; pend_pause = 0;
  endtask

  task automatic model_tick();
    bit u, p;
    u = pend_up; p = pend_pause;
    pend_up = 0; pend_pause = 0;
    m_col = 0;
    case (m_state)
      S_INI:   if (u) begin model_new_game(); m_state = S_GAME; m_msg = 0; end
               else m_msg = (m_msg + 1) % 64;
      S_GAME:  if (m_crash()) begin
                 m_state = S_DONE; m_col = 1;
                 if (m_score > m_hi) m_hi = m_score;
               end else begin
                 for (int i = 0; i < NOBS; i++) begin
                   if (m_x[i] <= DESPAWN) begin
                     m_x[i]   = SPAWN;
                     m_spd[i] = (m_spd[i] == SPMAX) ? SPMIN : m_spd[i] + 1;
                   end else m_x[i] -= m_spd[i];
                 end
                 if (m_air < 0) begin
                   if (u) m_air = 0;
                 end else begin
                   m_air++;
                   if (height(m_air) <= 0) m_air = -1;
                 end
                 if (m_score < SMAX) m_score++;
                 if (p) m_state = S_PAUSE;
               end
      S_PAUSE: if (p) begin m_state = S_GAME; m_msg = 0; end
               else m_msg = (m_msg + 1) % 64;
      default: if (u) begin m_state = S_INI; m_msg = 0; end
               else m_msg = (m_msg + 1) % 64;
    endcase
  endtask

  task automatic set_pixel();
    int h, v, i;
    case ($urandom_range(3))
      0: begin h = int'($urandom_range(799)); v = int'($urandom_range(599)); end
      1: begin h = DINO_X - 5 + int'($urandom_range(60)); v = m_ypos() - 55 + int'($urandom_range(60)); end
      2: begin
           i = int'($urandom_range(NOBS - 1));
           h = m_x[i] - 30 + int'($urandom_range(60));
           v = GROUND - BLK - 5 + int'($urandom_range(60));
         end
      default: begin h = 420 + int'($urandom_range(100)); v = 210 + int'($urandom_range(120)); end
    endcase
    if (h < 0) h = 0;
    if (h > 1023) h = 1023;
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    px_h = h; px_v = v; px_b = ($urandom_range(7) != 0);
    bus.hCount = 10'(h);
    bus.vCount = 10'(v);
    bus.bright = px_b;
  endtask

  task automatic push_exp();
    exp_t e;
    e.st = m_state; e.sc = m_score; e.hi = m_hi; e.col = m_col;
    e.rgb = model_rgb(px_h, px_v, px_b);
    exp_q.push_back(e);
  endtask

  // launch while an obstacle is at the distance that lets the dino clear it
  function automatic bit want_jump();
    if (m_air >= 0) return 1'b0;
    for (int i = 0; i < NOBS; i++)
      if (m_x[i] > 275 + 2 * m_spd[i] && m_x[i] <= 275 + 3 * m_spd[i]) return ($urandom_range(9) != 0);
    return 1'b0;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (bus.tick || rst) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("state",    int'(bus.state),    e.st);
          chk("score",    int'(bus.score),    e.sc);
          chk("hi_score", int'(bus.hi_score), e.hi);
          chk("collide",  int'(bus.collide),  e.col);
          chk("rgb",      int'(bus.rgb),      e.rgb);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_chk=%0d", n_chk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin : stimulus
    bit ue, pe, ub, uw, pb, pw;
    bus.tick = 1'b0; bus.up = 1'b0; bus.pause = 1'b0;
    model_reset();
    set_pixel();
    push_exp();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int s = 0; s < N_STEPS; s++) begin
      if (s == 1200 || s == 2100) begin
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        set_pixel();
        push_exp();
        @(posedge clk); #1;
        rst = 1'b0;
      end
      ue = 0; pe = 0;
      case (m_state)
        S_GAME:  begin
                   ue = want_jump() || ($urandom_range(11) == 0);
                   pe = ($urandom_range(49) == 0);
                 end
        S_PAUSE: begin
                   pe = ($urandom_range(7) == 0);
                   ue = ($urandom_range(5) == 0);
                 end
        default: ue = ($urandom_range(5) == 0);
      endcase
      ub = ue && ($urandom_range(1) == 0); uw = ue && !ub;
      pb = pe && ($urandom_range(1) == 0); pw = pe && !pb;
      @(posedge clk); #1;
      bus.up = ub; bus.pause = pb;
      if (ub) pend_up = 1;
      if (pb) pend_pause = 1;
      @(posedge clk); #1;
      bus.up = uw; bus.pause = pw; bus.tick = 1'b1;
      if (uw) pend_up = 1;
      if (pw) pend_pause = 1;
      @(posedge clk); #1;
      bus.tick = 1'b0; bus.up = 1'b0; bus.pause = 1'b0;
      model_tick();
      set_pixel();
      push_exp();
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
